// File: rtl/des_pkg.sv
// Shared DES constants for the iterative decrypt core: permutation tables,
// S-boxes, key shift schedule, FSM states and the table-driven permute helper.
package des_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   // Tables hold 1-based DES bit indices; entries past the used length are 0.
   typedef int tbl_t [64];
   typedef int sbox_t [8][4][16];
   typedef int shift_t [16];

   localparam tbl_t IP_TBL = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7};

   localparam tbl_t FP_TBL = '{
      40,  8, 48, 16, 56, 24, 64, 32,
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25};

   localparam tbl_t PC1_TBL = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4,
       0,  0,  0,  0,  0,  0,  0,  0};

   localparam tbl_t PC2_TBL = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32,
       0,  0,  0,  0,  0,  0,  0,  0,
       0,  0,  0,  0,  0,  0,  0,  0};

   localparam tbl_t E_TBL = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1,
       0,  0,  0,  0,  0,  0,  0,  0,
       0,  0,  0,  0,  0,  0,  0,  0};

   localparam tbl_t P_TBL = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25,
       0,  0,  0,  0,  0,  0,  0,  0,
       0,  0,  0,  0,  0,  0,  0,  0,
       0,  0,  0,  0,  0,  0,  0,  0,
       0,  0,  0,  0,  0,  0,  0,  0};

   // Encryption left-shift amounts s[1..16]; decryption walks them backwards.
   localparam shift_t SHIFT_TBL = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam sbox_t SBOX_TBL = '{
      '{'{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7},
        '{ 0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8},
        '{ 4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0},
        '{15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13}},
      '{'{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10},
        '{ 3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5},
        '{ 0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15},
        '{13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9}},
      '{'{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8},
        '{13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1},
        '{13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7},
        '{ 1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12}},
      '{'{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15},
        '{13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9},
        '{10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4},
        '{ 3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14}},
      '{'{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
        '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
        '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
        '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}},
      '{'{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11},
        '{10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8},
        '{ 9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6},
        '{ 4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13}},
      '{'{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1},
        '{13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6},
        '{ 1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2},
        '{ 6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12}},
      '{'{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7},
        '{ 1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2},
        '{ 7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8},
        '{ 2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}}};

   // DES index n of a srcW-wide source is vector bit (srcW - n); the result is
   // left-justified into the low dstW bits of the return value.
   function automatic logic [63:0] permute(input logic [63:0] src, input int srcW,
                                           input int dstW, input tbl_t tbl);
      logic [63:0] res;
      logic [5:0]  srcIdx;
      logic [5:0]  dstIdx;
      res = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < dstW) begin
            srcIdx      = 6'(srcW - tbl[i]);
            dstIdx      = 6'(dstW - 1 - i);
            res[dstIdx] = src[srcIdx];
         end
      end
      return res;
   endfunction

   function automatic logic keyParityBad(input logic [63:0] k);
      logic bad;
      bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (!(^k[8*b +: 8])) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/des_feistel.sv
// Single combinational DES round: {L,R} -> {R, L ^ P(S(E(R) ^ K))}.
module des_feistel
   import des_pkg::*;
(
   input  logic [63:0] lr_i,
   input  logic [47:0] subKey_i,
   output logic [63:0] lr_o
);

   logic [31:0] left;
   logic [31:0] right;
   logic [47:0] expanded;
   logic [47:0] mixed;
   logic [31:0] sOut;
   logic [31:0] fOut;

   assign left     = lr_i[63:32];
   assign right    = lr_i[31:0];
   assign expanded = 48'(permute({32'h0, right}, 32, 48, E_TBL));
   assign mixed    = expanded ^ subKey_i;

   // S1 consumes the top six bits and feeds the top nibble.
   for (genvar g = 0; g < 8; g++) begin : gSbox
      des_sbox #(.BOX(3'(g))) uSbox (
         .in_i  (mixed[47-6*g -: 6]),
         .out_o (sOut[31-4*g -: 4])
      );
   end

   assign fOut = 32'(permute({32'h0, sOut}, 32, 32, P_TBL));
   assign lr_o = {right, left ^ fOut};

endmodule

// File: rtl/des_sbox.sv
// One DES S-box selected by BOX (0 = S1): outer bits pick the row, inner four the column.
module des_sbox
   import des_pkg::*;
#(
   parameter logic [2:0] BOX = 3'd0
) (
   input  logic [5:0] in_i,
   output logic [3:0] out_o
);

   assign out_o = 4'(SBOX_TBL[BOX][{in_i[5], in_i[0]}][in_i[4:1]]);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per cycle with subkeys K16..K1
// produced by rotating the C/D halves right, results returned over valid/ready.
module des_decrypt_iter
   import des_pkg::*;
#(
   parameter logic PARITY_CHECK = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] cipher,
   input  logic [63:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] plain,
   output logic        key_err,
   output logic        busy
);

   state_t      state_q;
   logic [63:0] lr_q;
   logic [27:0] c_q;
   logic [27:0] d_q;
   logic [3:0]  cnt_q;
   logic        parErr_q;
   logic        inReady_q;
   logic        outValid_q;
   logic [63:0] plain_q;
   logic        keyErr_q;
   logic        busy_q;

   logic [47:0] subKey_d;
   logic [63:0] lr_d;
   logic [27:0] c_d;
   logic [27:0] d_d;
   logic [63:0] plain_d;
   logic [63:0] ipCipher;
   logic [55:0] pc1Key;
   logic        keyBad;
   logic        shiftOne;

   assign ipCipher = permute(cipher, 64, 64, IP_TBL);
   assign pc1Key   = 56'(permute(key, 64, 56, PC1_TBL));
   assign keyBad   = PARITY_CHECK & keyParityBad(key);
   assign subKey_d = 48'(permute({8'h00, c_q, d_q}, 56, 48, PC2_TBL));

   des_feistel uRound (
      .lr_i     (lr_q),
      .subKey_i (subKey_d),
      .lr_o     (lr_d)
   );

   // Round cnt uses s[16-cnt]; after all 16 rotations C/D are back at C0/D0.
   assign shiftOne = (SHIFT_TBL[~cnt_q] == 1);
   assign c_d      = shiftOne ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
   assign d_d      = shiftOne ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};

   // The final swap undoes the half exchange of the last round.
   assign plain_d  = permute({lr_d[31:0], lr_d[63:32]}, 64, 64, FP_TBL);

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lr_q       <= '0;
         c_q        <= '0;
         d_q        <= '0;
         cnt_q      <= '0;
         parErr_q   <= 1'b0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         plain_q    <= '0;
         keyErr_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && inReady_q) begin
                  lr_q      <= ipCipher;
                  c_q       <= pc1Key[55:28];
                  d_q       <= pc1Key[27:0];
                  cnt_q     <= '0;
                  parErr_q  <= keyBad;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ROUND;
               end
            end
            ROUND: begin
               if (parErr_q) begin
                  parErr_q   <= 1'b0;
                  plain_q    <= '0;
                  keyErr_q   <= 1'b1;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  lr_q  <= lr_d;
                  c_q   <= c_d;
                  d_q   <= d_d;
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     plain_q    <= plain_d;
                     outValid_q <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  keyErr_q   <= 1'b0;
                  inReady_q  <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign plain     = plain_q;
   assign key_err   = PARITY_CHECK & keyErr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: a plain instance and a parity-checking
// instance share the same stimulus; known DES vectors give the expected plaintext.
module tb_des_decrypt_iter;

   localparam logic [63:0] KEY1    = 64'h133457799BBCDFF1;
   localparam logic [63:0] CIPHER1 = 64'h85E813540F0AB405;
   localparam logic [63:0] PLAIN1  = 64'h0123456789ABCDEF;
   localparam logic [63:0] KEY2    = 64'h0E329232EA6D0D73;
   localparam logic [63:0] CIPHER2 = 64'h0000000000000000;
   localparam logic [63:0] PLAIN2  = 64'h8787878787878787;
   localparam logic [63:0] KEYBAD  = 64'h133457799BBCDFF0;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic        outReady;
   logic [63:0] cipher;
   logic [63:0] key;

   logic        inReady0, outValid0, keyErr0, busy0;
   logic [63:0] plain0;
   logic        inReady1, outValid1, keyErr1, busy1;
   logic [63:0] plain1;

   int vectors     = 0;
   int miscompares = 0;
   int latency;

   always #5 clk = ~clk;

   des_decrypt_iter #(.PARITY_CHECK(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
      .cipher(cipher), .key(key), .out_valid(outValid0), .out_ready(outReady),
      .plain(plain0), .key_err(keyErr0), .busy(busy0)
   );

   des_decrypt_iter #(.PARITY_CHECK(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
      .cipher(cipher), .key(key), .out_valid(outValid1), .out_ready(outReady),
      .plain(plain1), .key_err(keyErr1), .busy(busy1)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Presents one block for a single accept edge, then scrambles the inputs.
   task automatic applyStimulus(input logic [63:0] c, input logic [63:0] k);
      cipher  = c;
      key     = k;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      cipher  = {$urandom(), $urandom()};
      key     = {$urandom(), $urandom()};
   endtask

   // Counts edges until the selected instance raises out_valid (bounded).
   task automatic waitValid(input int which, output int n);
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         seen = (which == 0) ? outValid0 : outValid1;
      end
   endtask

   initial begin
      rst      = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b0;
      cipher   = '0;
      key      = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready",  64'(inReady0),  64'd1);
      checkOutput("rst_out_valid", 64'(outValid0), 64'd0);
      checkOutput("rst_plain",     plain0,         64'd0);
      checkOutput("rst_key_err",   64'(keyErr1),   64'd0);
      checkOutput("rst_busy",      64'(busy0),     64'd0);
      rst = 1'b0;

      $display("[TB] vector 1 with inputs scrambled after accept");
      outReady = 1'b1;
      applyStimulus(CIPHER1, KEY1);
      checkOutput("v1_busy", 64'(busy0), 64'd1);
      waitValid(0, latency);
      checkOutput("v1_latency", 64'(latency), 64'd16);
      checkOutput("v1_plain",   plain0,       PLAIN1);
      checkOutput("v1_key_err", 64'(keyErr0), 64'd0);
      checkOutput("v1_plain_pc", plain1,      PLAIN1);
      @(posedge clk);
      #1;
      checkOutput("v1_release_valid", 64'(outValid0), 64'd0);
      checkOutput("v1_release_ready", 64'(inReady0),  64'd1);

      $display("[TB] vector 2 with out_ready held low");
      outReady = 1'b0;
      applyStimulus(CIPHER2, KEY2);
      waitValid(0, latency);
      checkOutput("v2_latency", 64'(latency), 64'd16);
      checkOutput("v2_plain",   plain0,       PLAIN2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("v2_hold_plain", plain0,          PLAIN2);
         checkOutput("v2_hold_valid", 64'(outValid0),  64'd1);
         checkOutput("v2_hold_ready", 64'(inReady0),   64'd0);
      end
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("v2_release_ready", 64'(inReady0), 64'd1);

      $display("[TB] back-to-back blocks");
      cipher  = CIPHER1;
      key     = KEY1;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      cipher = CIPHER2;
      key    = KEY2;
      waitValid(0, latency);
      checkOutput("b2b_first_latency", 64'(latency), 64'd16);
      checkOutput("b2b_first_plain",   plain0,       PLAIN1);
      @(posedge clk);
      #1;
      checkOutput("b2b_idle_ready", 64'(inReady0),  64'd1);
      checkOutput("b2b_idle_valid", 64'(outValid0), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("b2b_second_busy",  64'(busy0),    64'd1);
      checkOutput("b2b_second_ready", 64'(inReady0), 64'd0);
      inValid = 1'b0;
      waitValid(0, latency);
      checkOutput("b2b_second_latency", 64'(latency), 64'd16);
      checkOutput("b2b_second_plain",   plain0,       PLAIN2);
      @(posedge clk);
      #1;

      $display("[TB] key with an even-parity byte");
      applyStimulus(CIPHER1, KEYBAD);
      waitValid(1, latency);
      checkOutput("par_latency", 64'(latency), 64'd1);
      checkOutput("par_plain",   plain1,       64'd0);
      checkOutput("par_key_err", 64'(keyErr1), 64'd1);
      checkOutput("par_nocheck_busy", 64'(busy0), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("par_err_cleared", 64'(keyErr1),  64'd0);
      checkOutput("par_back_idle",   64'(inReady1), 64'd1);
      waitValid(0, latency);
      checkOutput("par_nocheck_latency", 64'(latency), 64'd14);
      checkOutput("par_nocheck_plain",   plain0,       PLAIN1);
      checkOutput("par_nocheck_key_err", 64'(keyErr0), 64'd0);
      @(posedge clk);
      #1;

      $display("[TB] reset in the middle of the rounds");
      applyStimulus(CIPHER1, KEY1);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_rst_in_ready",  64'(inReady0),  64'd1);
      checkOutput("mid_rst_out_valid", 64'(outValid0), 64'd0);
      checkOutput("mid_rst_busy",      64'(busy0),     64'd0);
      checkOutput("mid_rst_busy_pc",   64'(busy1),     64'd0);
      rst = 1'b0;
      applyStimulus(CIPHER1, KEY1);
      waitValid(0, latency);
      checkOutput("post_rst_latency", 64'(latency), 64'd16);
      checkOutput("post_rst_plain",   plain0,       PLAIN1);
      @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
